// File: rtl/debug_abstract_ctrl.sv
// -----------------------------------------------------------------------------
// debug_abstract_ctrl
//
// Abstract-command engine for a RISC-V style debug module. It accepts an
// "access register" command from the DMI side and validates it. While the
// command runs it drives a single register-access request to the halted hart.
// It reports progress and errors through an abstractcs-style status word.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   cmd_wr / cmd_wdata       abstract command write strobe and command word
//   abscs_wr / abscs_wdata   abstractcs write (cmderr[10:8] is write-1-to-clear)
//   data0_wr / data0_wdata   data0 write from the DMI side
//   data0_rdata              current data0
//   abscs_rdata              abstractcs read value (busy, cmderr, datacount=1)
//   hart_halted              target hart is in debug halt
//   reg_req/we/addr/wdata    register-access request to the hart
//   reg_ack/err/rdata        hart completion, fault flag and read data
//   busy                     command in progress
//
// Optional feature: define DBG_CMD_TIMEOUT_EN to abort a register access that
// has not been acknowledged within 255 cycles. The access then ends with
// cmderr=3. Without the macro the engine waits indefinitely for reg_ack.
// -----------------------------------------------------------------------------
module debug_abstract_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_wdata,
  input  logic        abscs_wr,
  input  logic [31:0] abscs_wdata,
  input  logic        data0_wr,
  input  logic [31:0] data0_wdata,
  output logic [31:0] data0_rdata,
  output logic [31:0] abscs_rdata,
  input  logic        hart_halted,
  output logic        reg_req,
  output logic        reg_we,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  input  logic        reg_err,
  input  logic [31:0] reg_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_BUSY      = 3'd1;
  localparam logic [2:0] ERR_NOTSUP    = 3'd2;
  localparam logic [2:0] ERR_EXCEPTION = 3'd3;
  localparam logic [2:0] ERR_HALT      = 3'd4;

  // Highest legal regno: CSRs 0x0000-0x0FFF followed by GPRs 0x1000-0x101F.
  localparam logic [15:0] REGNO_MAX    = 16'h101F;

  state_e      state_q,     state_d;
  logic [2:0]  cmderr_q,    cmderr_d;
  logic [31:0] data0_q,     data0_d;
  logic        reg_we_q,    reg_we_d;
  logic [15:0] reg_addr_q,  reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
`ifdef DBG_CMD_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q,   tmo_cnt_d;
`endif

  // Command word fields.
  logic [7:0]  cmd_type;
  logic [2:0]  cmd_size;
  logic        cmd_transfer;
  logic        cmd_write;
  logic [15:0] cmd_regno;

  assign cmd_type     = cmd_wdata[31:24];
  assign cmd_size     = cmd_wdata[22:20];
  assign cmd_transfer = cmd_wdata[17];
  assign cmd_write    = cmd_wdata[16];
  assign cmd_regno    = cmd_wdata[15:0];

  // Fields this engine never looks at (reserved/postexec/aarpostincrement and
  // the read-only parts of abstractcs).
  logic unused_bits;
  assign unused_bits = ^{cmd_wdata[23], cmd_wdata[19:18],
                         abscs_wdata[31:11], abscs_wdata[7:0]};

  logic cmd_unsupported;
  logic cmd_bad_regno;
  logic any_wr;
  logic [31:0] data0_eff;

  // Only 32-bit register accesses are supported; aarsize is irrelevant when
  // nothing is transferred.
  assign cmd_unsupported = (cmd_type != 8'h00) ||
                           (cmd_transfer && (cmd_size != 3'd2));
  assign cmd_bad_regno   = cmd_transfer && (cmd_regno > REGNO_MAX);
  assign any_wr          = cmd_wr | abscs_wr | data0_wr;
  // A data0 write in the same cycle as the command is seen by the command.
  assign data0_eff       = data0_wr ? data0_wdata : data0_q;

  // NOTE: every variable gets its hold value first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cmderr_d    = cmderr_q;
    data0_d     = data0_q;
    reg_we_d    = reg_we_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
`ifdef DBG_CMD_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (data0_wr) data0_d = data0_wdata;
        if (abscs_wr) cmderr_d = cmderr_q & ~abscs_wdata[10:8];
        // Validation uses the error state from before any same-cycle clear.
        if (cmd_wr && (cmderr_q == ERR_NONE)) begin
          if (cmd_unsupported) begin
            cmderr_d = ERR_NOTSUP;
          end else if (cmd_bad_regno) begin
            cmderr_d = ERR_EXCEPTION;
          end else if (!hart_halted) begin
            cmderr_d = ERR_HALT;
          end else if (cmd_transfer) begin
            state_d     = ST_EXEC;
            reg_we_d    = cmd_write;
            reg_addr_d  = cmd_regno;
            reg_wdata_d = data0_eff;
`ifdef DBG_CMD_TIMEOUT_EN
            tmo_cnt_d   = 8'd0;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_EXEC: begin
        if (any_wr && (cmderr_q == ERR_NONE)) cmderr_d = ERR_BUSY;
`ifdef DBG_CMD_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        if (reg_ack) begin
          state_d = ST_DONE;
          // A hart fault outranks a same-cycle busy error.
          if (reg_err) begin
            if (cmderr_q == ERR_NONE) cmderr_d = ERR_EXCEPTION;
          end else if (!reg_we_q) begin
            data0_d = reg_rdata;
          end
        end
`ifdef DBG_CMD_TIMEOUT_EN
        // 254 means this is the 255th unacknowledged request cycle.
        else if (tmo_cnt_q == 8'd254) begin
          state_d = ST_DONE;
          if (cmderr_q == ERR_NONE) cmderr_d = ERR_EXCEPTION;
        end
`endif
      end

      ST_DONE: begin
        if (any_wr && (cmderr_q == ERR_NONE)) cmderr_d = ERR_BUSY;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the values from
  // before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmderr_q    <= ERR_NONE;
      data0_q     <= 32'h0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 16'h0;
      reg_wdata_q <= 32'h0;
`ifdef DBG_CMD_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmderr_q    <= cmderr_d;
      data0_q     <= data0_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
`ifdef DBG_CMD_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign reg_req     = (state_q == ST_EXEC);
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign data0_rdata = data0_q;
  // progbufsize=0, busy[12], relaxedpriv=0, cmderr[10:8], datacount=1.
  assign abscs_rdata = {19'b0, busy, 1'b0, cmderr_q, 4'b0, 4'd1};

endmodule

// File: tb/tb_debug_abstract_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_abstract_ctrl
//
// Self-checking bench for debug_abstract_ctrl. It covers the reset state, a
// table of directed cycles, the unacknowledged-access case (with or without
// DBG_CMD_TIMEOUT_EN) and reset mid-access. It then runs a randomized phase
// checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_debug_abstract_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_wr;
  logic [31:0] cmd_wdata;
  logic        abscs_wr;
  logic [31:0] abscs_wdata;
  logic        data0_wr;
  logic [31:0] data0_wdata;
  logic [31:0] data0_rdata;
  logic [31:0] abscs_rdata;
  logic        hart_halted;
  logic        reg_req;
  logic        reg_we;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic        reg_err;
  logic [31:0] reg_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  debug_abstract_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_wr      (cmd_wr),
    .cmd_wdata   (cmd_wdata),
    .abscs_wr    (abscs_wr),
    .abscs_wdata (abscs_wdata),
    .data0_wr    (data0_wr),
    .data0_wdata (data0_wdata),
    .data0_rdata (data0_rdata),
    .abscs_rdata (abscs_rdata),
    .hart_halted (hart_halted),
    .reg_req     (reg_req),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_ack     (reg_ack),
    .reg_err     (reg_err),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] abscs_exp(input bit b, input logic [2:0] e);
    logic [31:0] w;
    w = 32'h0000_0001;
    w[12] = b;
    w[10:8] = e;
    return w;
  endfunction

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_wr = 1'b0; cmd_wdata = 32'h0;
    abscs_wr = 1'b0; abscs_wdata = 32'h0;
    data0_wr = 1'b0; data0_wdata = 32'h0;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = 32'h0;
  endtask

  typedef struct {
    bit          cw;   logic [31:0] cd;
    bit          aw;   logic [31:0] ad;
    bit          dw;   logic [31:0] dd;
    bit          halt;
    bit          ack;  bit err; logic [31:0] rd;
    bit          e_busy;
    bit          e_req;
    logic [2:0]  e_err;
    logic [31:0] e_d0;
    bit          chk;  bit e_we; logic [15:0] e_addr; logic [31:0] e_wd;
  } vec_t;

  localparam bit          Y   = 1'b1;
  localparam bit          N   = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [15:0] Z16 = 16'h0;
  localparam logic [31:0] CLR = 32'h0000_0700;

  // ---------------- reference model (transaction level) ----------------
  bit          m_inflight;   // access issued, waiting for the hart
  bit          m_finish;     // one-cycle completion slot
  logic [31:0] m_d0;
  logic [2:0]  m_err;
  bit          m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wd;
  int          m_tmo;

  task automatic model_reset();
    m_inflight = 0; m_finish = 0; m_d0 = 32'h0; m_err = 3'd0;
    m_we = 0; m_addr = 16'h0; m_wd = 32'h0; m_tmo = 0;
  endtask

  // Applies the current inputs to the model: the state after the coming edge.
  task automatic model_cycle();
    bit         wr_any;
    logic [2:0] err_old;
    int         ctype, csize, regno;
    bit         xfer;
    wr_any  = cmd_wr || abscs_wr || data0_wr;
    err_old = m_err;
    if (m_inflight || m_finish) begin
      if (wr_any && err_old == 3'd0) m_err = 3'd1;
      if (m_finish) begin
        m_finish = 0;
      end else if (reg_ack) begin
        if (reg_err) begin
          if (err_old == 3'd0) m_err = 3'd3;
        end else if (!m_we) begin
          m_d0 = reg_rdata;
        end
        m_inflight = 0; m_finish = 1;
      end else begin
`ifdef DBG_CMD_TIMEOUT_EN
        m_tmo++;
        if (m_tmo == 255) begin
          if (err_old == 3'd0) m_err = 3'd3;
          m_inflight = 0; m_finish = 1;
        end
`endif
      end
    end else begin
      if (data0_wr) m_d0 = data0_wdata;
      if (abscs_wr) m_err = m_err & ~abscs_wdata[10:8];
      if (cmd_wr && err_old == 3'd0) begin
        ctype = int'(cmd_wdata[31:24]);
        csize = int'(cmd_wdata[22:20]);
        xfer  = cmd_wdata[17];
        regno = int'(cmd_wdata[15:0]);
        if (ctype != 0 || (xfer && csize != 2))   m_err = 3'd2;
        else if (xfer && regno > 32'h101F)        m_err = 3'd3;
        else if (!hart_halted)                    m_err = 3'd4;
        else if (xfer) begin
          m_inflight = 1; m_we = cmd_wdata[16];
          m_addr = cmd_wdata[15:0]; m_wd = m_d0; m_tmo = 0;
        end else begin
          m_finish = 1;
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; hart_halted = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy),    32'h0);
    check("rst_req",   32'(reg_req), 32'h0);
    check("rst_we",    32'(reg_we),  32'h0);
    check("rst_addr",  32'(reg_addr), 32'h0);
    check("rst_wdata", reg_wdata,    32'h0);
    check("rst_abscs", abscs_rdata,  32'h0000_0001);
    check("rst_data0", data0_rdata,  32'h0);
    rst = 1'b0;

    // ---------------- directed table ----------------
    //        cw cd             aw ad   dw dd            ht ack err rd             busy req err   d0              chk we addr      wd
    tbl.push_back('{Y,32'h00221005,N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd0,32'h0,          Y,N,16'h1005,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd0,32'h0,          Y,N,16'h1005,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,Y,N,32'hDEADBEEF, Y,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00231001,N,Z32,N,Z32,        N,N,N,Z32,          N,N,3'd4,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00321001,N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd2,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00222000,N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd2,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00222000,N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd3,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00000000,N,Z32,N,Z32,        Y,N,N,Z32,          Y,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'hDEADBEEF,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00231008,N,Z32,Y,32'h12345678,Y,N,N,Z32,         Y,Y,3'd0,32'h12345678,   Y,Y,16'h1008,32'h12345678});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,Y,N,32'hCAFEF00D, Y,N,3'd0,32'h12345678,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h12345678,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00221003,N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd0,32'h12345678,   Y,N,16'h1003,32'h12345678});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,Y,Y,32'hFFFFFFFF, Y,N,3'd3,32'h12345678,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd3,32'h12345678,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,32'h00000100,N,Z32,Y,N,N,Z32,         N,N,3'd2,32'h12345678,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,32'h00000600,N,Z32,Y,N,N,Z32,         N,N,3'd0,32'h12345678,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00221001,N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd0,32'h12345678,   Y,N,16'h1001,32'h12345678});
    tbl.push_back('{Y,32'h00221002,N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd1,32'h12345678,   Y,N,16'h1001,32'h12345678});
    tbl.push_back('{N,Z32,         N,Z32,Y,Z32,        Y,N,N,Z32,          Y,Y,3'd1,32'h12345678,   Y,N,16'h1001,32'h12345678});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,Y,N,32'hA5A5A5A5, Y,N,3'd1,32'hA5A5A5A5,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd1,32'hA5A5A5A5,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'hA5A5A5A5,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,Y,N,32'h11111111, N,N,3'd0,32'hA5A5A5A5,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00220300,N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd0,32'hA5A5A5A5,   Y,N,16'h0300,32'hA5A5A5A5});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        N,N,N,Z32,          Y,Y,3'd0,32'hA5A5A5A5,   Y,N,16'h0300,32'hA5A5A5A5});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        N,Y,N,32'h00000001, Y,N,3'd0,32'h00000001,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h00000001,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00221020,N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd3,32'h00000001,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h00000001,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h0022101F,N,Z32,N,Z32,        Y,N,N,Z32,          Y,Y,3'd0,32'h00000001,   Y,N,16'h101F,32'h00000001});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,Y,N,32'h00000007, Y,N,3'd0,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h01221001,N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd2,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00305000,N,Z32,N,Z32,        Y,N,N,Z32,          Y,N,3'd0,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         N,Z32,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{Y,32'h00000000,N,Z32,N,Z32,        N,N,N,Z32,          N,N,3'd4,32'h00000007,   N,N,Z16,Z32});
    tbl.push_back('{N,Z32,         Y,CLR,N,Z32,        Y,N,N,Z32,          N,N,3'd0,32'h00000007,   N,N,Z16,Z32});

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_wr = tbl[i].cw;   cmd_wdata = tbl[i].cd;
      abscs_wr = tbl[i].aw; abscs_wdata = tbl[i].ad;
      data0_wr = tbl[i].dw; data0_wdata = tbl[i].dd;
      hart_halted = tbl[i].halt;
      reg_ack = tbl[i].ack; reg_err = tbl[i].err; reg_rdata = tbl[i].rd;
      step();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("vec%0d_req", i), 32'(reg_req), 32'(tbl[i].e_req));
      check($sformatf("vec%0d_abscs", i), abscs_rdata,
            abscs_exp(tbl[i].e_busy, tbl[i].e_err));
      check($sformatf("vec%0d_data0", i), data0_rdata, tbl[i].e_d0);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_we", i), 32'(reg_we), 32'(tbl[i].e_we));
        check($sformatf("vec%0d_addr", i), 32'(reg_addr), 32'(tbl[i].e_addr));
        check($sformatf("vec%0d_wdata", i), reg_wdata, tbl[i].e_wd);
      end
    end
    idle_inputs();
    hart_halted = 1'b1;

    // ---------------- unacknowledged access ----------------
    begin
      int n_req;
      cmd_wr = 1'b1; cmd_wdata = 32'h00221001;
      step();
      cmd_wr = 1'b0; cmd_wdata = 32'h0;
      n_req = 0;
      for (int i = 0; i < 1000; i++) begin
        if (!reg_req) break;
        n_req++;
        if (i < 999) step();
      end
`ifdef DBG_CMD_TIMEOUT_EN
      if (reg_req) step();
      check("tmo_req_cycles", 32'(n_req), 32'd255);
      check("tmo_abscs", abscs_rdata, abscs_exp(1'b1, 3'd3));
      check("tmo_data0", data0_rdata, 32'h00000007);
      step();
      check("tmo_idle", 32'(busy), 32'h0);
      abscs_wr = 1'b1; abscs_wdata = CLR;
      step();
      abscs_wr = 1'b0; abscs_wdata = 32'h0;
      check("tmo_clear", abscs_rdata, 32'h0000_0001);
`else
      check("notmo_req_cycles", 32'(n_req), 32'd1000);
      check("notmo_req_1000", 32'(reg_req), 32'h1);
      reg_ack = 1'b1; reg_rdata = 32'h0BADF00D;
      step();
      reg_ack = 1'b0; reg_rdata = 32'h0;
      check("notmo_done", abscs_rdata, abscs_exp(1'b1, 3'd0));
      check("notmo_data0", data0_rdata, 32'h0BADF00D);
      step();
      check("notmo_idle", 32'(busy), 32'h0);
`endif
    end

    // ---------------- reset in the middle of an access ----------------
    cmd_wr = 1'b1; cmd_wdata = 32'h00221002;
    step();
    step();   // second write while busy sets cmderr=1
    cmd_wr = 1'b0; cmd_wdata = 32'h0;
    check("pre_rst_abscs", abscs_rdata, abscs_exp(1'b1, 3'd1));
    #2 rst = 1'b1;
    #1;
    check("arst_req",   32'(reg_req),  32'h0);
    check("arst_busy",  32'(busy),     32'h0);
    check("arst_abscs", abscs_rdata,   32'h0000_0001);
    check("arst_data0", data0_rdata,   32'h0);
    check("arst_addr",  32'(reg_addr), 32'h0);
    check("arst_wdata", reg_wdata,     32'h0);
    check("arst_we",    32'(reg_we),   32'h0);
    step();
    rst = 1'b0;
    reg_ack = 1'b1; reg_rdata = 32'h55AA55AA;
    step();
    reg_ack = 1'b0; reg_rdata = 32'h0;
    check("late_ack_busy",  32'(busy), 32'h0);
    check("late_ack_data0", data0_rdata, 32'h0);

    // ---------------- randomized phase against the model ----------------
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      int          r;
      logic [31:0] c;
      cmd_wr = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      c = $urandom;
      if (r < 8) c[31:24] = 8'h00;
      if (r < 6) begin
        c[22:20] = 3'd2;
        c[17]    = 1'b1;
      end else if (r == 6) begin
        c[17] = 1'b0;
      end
      case ($urandom_range(0, 3))
        0:       c[15:0] = 16'($urandom_range(0, 16'h0FFF));
        1, 2:    c[15:0] = 16'($urandom_range(16'h1000, 16'h1021));
        default: ;
      endcase
      cmd_wdata   = c;
      abscs_wr    = ($urandom_range(0, 5) == 0);
      abscs_wdata = $urandom;
      data0_wr    = ($urandom_range(0, 4) == 0);
      data0_wdata = $urandom;
      hart_halted = ($urandom_range(0, 7) != 0);
      reg_ack     = ($urandom_range(0, 2) == 0);
      reg_err     = ($urandom_range(0, 7) == 0);
      reg_rdata   = $urandom;
      model_cycle();
      step();
      check($sformatf("rnd%0d_busy", i), 32'(busy), 32'(m_inflight || m_finish));
      check($sformatf("rnd%0d_req", i), 32'(reg_req), 32'(m_inflight));
      check($sformatf("rnd%0d_abscs", i), abscs_rdata,
            abscs_exp(m_inflight || m_finish, m_err));
      check($sformatf("rnd%0d_data0", i), data0_rdata, m_d0);
      if (m_inflight) begin
        check($sformatf("rnd%0d_we", i), 32'(reg_we), 32'(m_we));
        check($sformatf("rnd%0d_addr", i), 32'(reg_addr), 32'(m_addr));
        check($sformatf("rnd%0d_wdata", i), reg_wdata, m_wd);
      end
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
